// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the clocked write front end of the latch FIFO.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fifo_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    REL   = 2'd3
  } state_t;

  localparam int DW_DEF        = 8;
  localparam int SETUP_CYC_DEF = 2;
  localparam int MAX_REQ       = 8;

  // Round-robin pick: first set bit of valid at or above ptr, wrapping
  // modulo n. The result is meaningless when no valid bit is set, so
  // callers must qualify it with |valid.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if ((i < n) && !found && valid[idx]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_hs_sync.sv
// Flop-chain synchroniser for an asynchronous level (e.g. the FIFO acknowledge).
// Latency: STAGES clock edges from input change to output change.
// Backpressure: none; a level is tracked continuously.
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  // Shift the asynchronous level through the chain; reset clears every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the latch FIFO write port; drives its 4-phase lr/la handshake.
// Latency: lr_r1 rises SETUP_CYC edges after accept; one byte per SETUP_CYC+2*SYNC_STAGES+3 cycles.
// Backpressure: req_ready only in IDLE with the synchronised ack low; a stalled ack holds REQ forever.
module fifo_wr_arbiter
  import fifo_ctl_pkg::*;
#(
  parameter  int NREQ        = 4,
  parameter  int DW          = DW_DEF,
  parameter  int SETUP_CYC   = SETUP_CYC_DEF,
  parameter  int SYNC_STAGES = 2,
  localparam int IW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      din,
  output logic               lr_r1,
  input  logic               la_r1,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic [15:0]        xfer_cnt
);

  localparam int CW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lr_q, lr_d;
  logic [DW-1:0]   din_q, din_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [15:0]     xfer_q, xfer_d;

  logic            la_sync;
  logic [7:0]      valid_ext;
  logic [2:0]      win3;
  logic [IW-1:0]   winner;
  logic            accept;

  // The FSM only ever looks at the synchronised acknowledge.
  hs_sync #(
    .STAGES (SYNC_STAGES)
  ) u_la_sync (
    .clk (clk),
    .rst (rst),
    .d   (la_r1),
    .q   (la_sync)
  );

  // Pick the round-robin winner and raise its ready strobe while idle with no stale ack.
  always_comb begin
    valid_ext              = '0;
    valid_ext[NREQ-1:0]    = req_valid;
    win3                   = rr_pick(valid_ext, 3'(ptr_q), NREQ);
    winner                 = win3[IW-1:0];
    accept                 = (state_q == IDLE) && !la_sync && (|req_valid) && rst;
    req_ready              = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Next-state logic for the handshake sequencer and its registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    din_d   = din_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    xfer_d  = xfer_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          din_d   = req_data[int'(winner)*DW +: DW];
          grant_d = winner;
          ptr_d   = (winner == IW'(NREQ-1)) ? '0 : winner + IW'(1);
          cnt_d   = CW'(SETUP_CYC-1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        // Bundling delay: din has been stable since accept before lr rises.
        if (cnt_q == '0) begin
          state_d = REQ;
          lr_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      REQ: begin
        if (la_sync) begin
          state_d = REL;
          lr_d    = 1'b0;
        end
      end
      REL: begin
        // Return-to-zero: din must stay put until the ack has dropped.
        if (!la_sync) begin
          state_d = IDLE;
          xfer_d  = xfer_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        lr_d    = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset pulls lr_r1 low without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lr_q    <= 1'b0;
      din_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
      din_q   <= din_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      xfer_q  <= xfer_d;
    end
  end

  assign lr_r1    = lr_q;
  assign din      = din_q;
  assign grant_id = grant_q;
  assign xfer_cnt = xfer_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural ack (loopback or held level).
// Latency: expectations derived by hand from SETUP_CYC=2, SYNC_STAGES=2.
// Backpressure: bench holds la_r1 low to model a full FIFO.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  din;
  logic        lr_r1;
  logic        la_r1;
  logic        busy;
  logic [1:0]  grant_id;
  logic [15:0] xfer_cnt;

  logic        loop_en;
  logic        la_man;
  int          total;
  int          bad;
  int          cyc;

  // Ideal zero-delay FIFO ack when looping back, else a bench-held level.
  assign la_r1 = loop_en ? lr_r1 : la_man;

  fifo_wr_arbiter #(
    .NREQ        (4),
    .DW          (8),
    .SETUP_CYC   (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .din       (din),
    .lr_r1     (lr_r1),
    .la_r1     (la_r1),
    .busy      (busy),
    .grant_id  (grant_id),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (req_ready == 4'b0000 && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $error("FAIL %s timeout waiting for req_ready observed=%0h expected=nonzero", tag, req_ready);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $error("FAIL %s timeout waiting for idle observed busy=%0b expected=0", tag, busy);
    end
  endtask

  initial begin
    int viol;
    int prev;
    int expi;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    loop_en   = 1'b0;
    la_man    = 1'b0;

    // Reset held with every requester asking.
    repeat (3) step();
    chk("rst_lr", lr_r1, 1'b0);
    chk("rst_din", din, 8'h00);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_xfer", xfer_cnt, 16'd0);
    rst = 1'b1;
    #1;
    chk("rst_first_pick", req_ready, 4'b0001);
    // Withdraw before any edge: nothing is accepted.
    req_valid = 4'b0000;
    step();
    chk("rst_withdraw_idle", busy, 1'b0);

    // Single transfer from requester 2 with loopback ack.
    req_data  = 32'h00A50000;
    req_valid = 4'b0100;
    loop_en   = 1'b1;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    step();
    chk("single_ready_drop", req_ready, 4'b0000);
    chk("single_din", din, 8'hA5);
    chk("single_grant", grant_id, 2'd2);
    chk("single_busy", busy, 1'b1);
    req_valid = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("single_lr", lr_r1, (k >= 2 && k <= 4) ? 1'b1 : 1'b0);
      chk("single_busy_k", busy, (k < 8) ? 1'b1 : 1'b0);
      chk("single_din_hold", din, 8'hA5);
    end
    chk("single_xfer", xfer_cnt, 16'd1);

    // Full FIFO: ack held low, request must hang in REQ.
    loop_en   = 1'b0;
    la_man    = 1'b0;
    req_data  = 32'h000000C3;
    req_valid = 4'b0001;
    #1;
    chk("full_ready", req_ready, 4'b0001);
    step();
    req_valid = 4'b1111;
    step();
    step();
    chk("full_lr_up", lr_r1, 1'b1);
    viol = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (lr_r1 !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000) viol++;
    end
    chk("full_hold", viol, 0);
    req_valid = 4'b0000;
    loop_en   = 1'b1;
    wait_idle("full_release");
    chk("full_xfer", xfer_cnt, 16'd2);
    chk("full_lr_down", lr_r1, 1'b0);
    chk("full_grant", grant_id, 2'd0);
    chk("full_din", din, 8'hC3);

    // Reset while lr_r1 is high.
    loop_en   = 1'b0;
    la_man    = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("mid_ready", req_ready, 4'b0010);
    step();
    req_valid = 4'b0000;
    step();
    step();
    chk("mid_lr_up", lr_r1, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_lr_async", lr_r1, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_xfer", xfer_cnt, 16'd0);
    chk("mid_din", din, 8'h00);
    step();
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    rst       = 1'b1;
    #1;
    chk("mid_ptr_zero", req_ready, 4'b0001);

    // Fairness: all valid, loopback; grants rotate, accepts 2+2*2+3 = 9 cycles apart.
    loop_en = 1'b1;
    prev    = 0;
    for (int n = 0; n < 6; n++) begin
      expi = n % 4;
      wait_ready("fair_wait");
      chk("fair_ready", req_ready, 4'b0001 << expi);
      if (n > 0) chk("fair_period", cyc - prev, 9);
      prev = cyc;
      step();
      chk("fair_grant", grant_id, expi);
      chk("fair_din", din, 8'h10 + expi);
    end
    req_valid = 4'b0000;
    wait_idle("fair_drain");
    chk("fair_xfer", xfer_cnt, 16'd6);

    // Stale ack while idle blocks grants until it has synchronised low.
    loop_en = 1'b0;
    la_man  = 1'b1;
    repeat (3) step();
    req_valid = 4'b0010;
    #1;
    chk("stale_ready0", req_ready, 4'b0000);
    chk("stale_busy", busy, 1'b0);
    step();
    chk("stale_ready1", req_ready, 4'b0000);
    la_man = 1'b0;
    #1;
    chk("stale_ready2", req_ready, 4'b0000);
    step();
    chk("stale_sync1", req_ready, 4'b0000);
    step();
    chk("stale_sync2", req_ready, 4'b0010);
    loop_en = 1'b1;
    step();
    chk("stale_grant", grant_id, 2'd1);
    chk("stale_busy_after", busy, 1'b1);
    req_valid = 4'b0000;
    wait_idle("stale_drain");
    chk("stale_xfer", xfer_cnt, 16'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
